// File: rtl/prefix_adder_pkg.sv
// prefix_adder_pkg: shared constants and index helpers for the pipelined
// Sklansky prefix adder.
//   DEFAULT_LEVELS : default number of prefix levels
//   partner_idx()  : bit that bit j combines with at Sklansky level i
//   combines()     : whether bit j combines (1) or passes through (0) at level i
package prefix_adder_pkg;

  localparam int unsigned DEFAULT_LEVELS = 3;

  // Highest bit of the lower neighbouring 2^i block: (j/2^i)*2^i-1.
  function automatic int unsigned partner_idx(input int unsigned j, input int unsigned i);
    return (j / (32'd1 << i)) * (32'd1 << i) - 32'd1;
  endfunction

  // Bit j combines at level i when its 2^i block number is odd.
  function automatic bit combines(input int unsigned j, input int unsigned i);
    return ((j >> i) % 32'd2) != 32'd0;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// prefix_level: one combinational Sklansky level over VEC_W-bit
// generate/propagate vectors.
//   LEVEL  : level index i (span 2^i)
//   VEC_W  : vector width
//   g_in, p_in   : group generate/propagate from the previous level
//   g_out, p_out : group generate/propagate after this level
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int unsigned LEVEL = 0,
  parameter int unsigned VEC_W = 9
) (
  input  logic [VEC_W-1:0] g_in,
  input  logic [VEC_W-1:0] p_in,
  output logic [VEC_W-1:0] g_out,
  output logic [VEC_W-1:0] p_out
);

  for (genvar j = 0; j < VEC_W; j++) begin : g_bit
    if (combines(j, LEVEL)) begin : g_cmb
      localparam int unsigned M = partner_idx(j, LEVEL);
      assign g_out[j] = g_in[j] | (p_in[j] & g_in[M]);
      assign p_out[j] = p_in[j] & p_in[M];
    end else begin : g_pass
      assign g_out[j] = g_in[j];
      assign p_out[j] = p_in[j];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: elastic, fully pipelined parallel-prefix adder.
// Stage 0 registers g/p of the operands; each of LEVELS further stages
// registers one Sklansky level. Results leave combinationally from the last
// stage register.
// Optional macro PREFIX_ADDER_SUB_EN adds the sub port (x - y when sub=1).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (x, y, carry_in[, sub])
//   out_valid/out_ready : result handshake (z, carry_out, overflow)
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int unsigned LEVELS = DEFAULT_LEVELS,
  parameter int unsigned WIDTH  = 2 ** LEVELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             overflow
);

  // Index 0 of g/p carries carry_in; index j+1 belongs to operand bit j.
  localparam int unsigned VEC_W  = WIDTH + 1;
  localparam int unsigned STAGES = LEVELS + 1;

  // Stage record sized by WIDTH.
  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] g;
    logic [VEC_W-1:0] p;
    logic [WIDTH-1:0] p_orig;
  } stage_t;

  stage_t           st_q [STAGES];
  stage_t           st_d [STAGES];
  logic [STAGES:0]  load_c;
  logic [VEC_W-1:0] lvl_g [LEVELS];
  logic [VEC_W-1:0] lvl_p [LEVELS];
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;

  // Per-stage load enables; backpressure ripples combinationally from out_ready.
  always_comb begin
    load_c         = '0;
    load_c[STAGES] = out_ready;
    for (int k = int'(LEVELS); k >= 0; k--) begin
      load_c[k] = !st_q[k].valid || load_c[k+1];
    end
  end

  assign in_ready = load_c[0];

  // Operand B and carry seen by stage 0.
  always_comb begin
    y_eff   = y;
    cin_eff = carry_in;
`ifdef PREFIX_ADDER_SUB_EN
    if (sub) begin
      y_eff   = ~y;
      cin_eff = 1'b1;
    end
`endif
  end

  // Prefix levels between consecutive stage registers.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    prefix_level #(
      .LEVEL (k),
      .VEC_W (VEC_W)
    ) u_level (
      .g_in  (st_q[k].g),
      .p_in  (st_q[k].p),
      .g_out (lvl_g[k]),
      .p_out (lvl_p[k])
    );
  end

  // Next contents of every stage.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) st_d[k] = '0;
    st_d[0].valid  = in_valid;
    st_d[0].g      = {x & y_eff, cin_eff};
    st_d[0].p      = {x ^ y_eff, 1'b0};
    st_d[0].p_orig = x ^ y_eff;
    for (int k = 1; k < int'(STAGES); k++) begin
      st_d[k].valid  = st_q[k-1].valid;
      st_d[k].g      = lvl_g[k-1];
      st_d[k].p      = lvl_p[k-1];
      st_d[k].p_orig = st_q[k-1].p_orig;
    end
  end

  // Stage registers; a stalled stage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load_c[k]) st_q[k] <= st_d[k];
      end
    end
  end

  // Result. When WIDTH == 2**LEVELS the top bit lies outside the tree's
  // reach, so it is finished here with one more combine. For narrower widths
  // G[WIDTH] already spans bit 0, whose propagate is 0, so the extra term is 0.
  always_comb begin
    out_valid = st_q[LEVELS].valid;
    carry_out = st_q[LEVELS].g[WIDTH] |
                (st_q[LEVELS].p[WIDTH] & st_q[LEVELS].g[WIDTH-1]);
    overflow  = st_q[LEVELS].g[WIDTH-1] ^ carry_out;
    z         = st_q[LEVELS].p_orig ^ st_q[LEVELS].g[WIDTH-1:0];
  end

endmodule
